intr_responder: RTL

Peripheral-side interrupt responder for one bus request level (BR4 or BR5) of the processor board. It collects level-sensitive requests from up to N controllers and raises a single `irq` line toward the CPU board's `irq_i[n]`. It answers the CPU's vector strobe (`istb_o[n]`) with the highest-priority pending vector on `ivec` and the `iack` acknowledge, then pulses a per-source clear back to the winning controller. One instance serves one level; the top level ORs the `ivec`/`iack` outputs of all instances.

---
 rtl/intr_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/intr_responder.sv
// intr_responder
// ----------------------------------------------------------------------------
// Peripheral-side interrupt responder for one bus request level. It gathers
// level-sensitive requests from N controllers into a single irq line. It answers
// the CPU vector strobe with the vector of the highest-priority pending source
// (source 0 is highest), then sends a one-cycle clear pulse back to that source.
//
// Ports:
//   clk_p    in   1     system clock, rising edge
//   rst_n    in   1     synchronous active-low reset
//   req      in   N     level requests, bit i held until source i is acked
//   vec_tab  in   9*N   vector table, bits [9i+8:9i] = vector of source i
//   irq      out  1     registered request toward the CPU board
//   istb     in   1     vector strobe from the CPU board
//   ivec     out  9     vector, zero whenever iack is low
//   iack     out  1     vector acknowledge
//   ack_src  out  N     one-hot, one-cycle clear pulse to the winning source
// ----------------------------------------------------------------------------
module intr_responder #(
    parameter int N = 8
) (
    input  logic           clk_p,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [9*N-1:0] vec_tab,
    output logic           irq,
    input  logic           istb,
    output logic [8:0]     ivec,
    output logic           iack,
    output logic [N-1:0]   ack_src
);

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        ACK,
        NOACK
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [N-1:0]   req_q;
    logic           istb_q;
    logic [N-1:0]   srv_mask;
    logic [N-1:0]   srv_mask_n;
    logic [N-1:0]   lowest;
    logic [8:0]     sel_vec;
    logic [8:0]     ivec_n;
    logic           iack_n;
    logic [N-1:0]   ack_src_n;
    logic           irq_n;

    // Isolate the lowest set bit of the registered requests: two's-complement
    // trick, gives the highest-priority pending source as a one-hot mask.
    assign lowest = req_q & (~req_q + N'(1));

    // Vector of the source currently being served, selected by the one-hot mask.
    always_comb begin
        sel_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (srv_mask[i]) begin
                sel_vec = sel_vec | vec_tab[9*i +: 9];
            end
        end
    end

    // A source already being served is masked out of irq so that the CPU only
    // sees requests that are still waiting.
    assign irq_n = |(req_q & ~srv_mask);

    // Next-state and next-output logic. A new cycle starts only on a rising
    // strobe, so a strobe still high from the previous cycle is ignored.
    always_comb begin
        state_n    = state;
        srv_mask_n = srv_mask;
        ivec_n     = ivec;
        iack_n     = iack;
        ack_src_n  = '0;
        unique case (state)
            IDLE: begin
                iack_n     = 1'b0;
                ivec_n     = '0;
                srv_mask_n = '0;
                if (istb && !istb_q) begin
                    if (|req_q) begin
                        srv_mask_n = lowest;
                        state_n    = SEL;
                    end else begin
                        state_n = NOACK;
                    end
                end
            end
            SEL: begin
                ivec_n    = sel_vec;
                iack_n    = 1'b1;
                ack_src_n = srv_mask;
                state_n   = ACK;
            end
            ACK: begin
                if (!istb) begin
                    iack_n     = 1'b0;
                    ivec_n     = '0;
                    srv_mask_n = '0;
                    state_n    = IDLE;
                end
            end
            NOACK: begin
                if (!istb) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, including a cycle
    // interrupted mid-acknowledge.
    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_q    <= '0;
            istb_q   <= 1'b0;
            srv_mask <= '0;
            irq      <= 1'b0;
            iack     <= 1'b0;
            ivec     <= '0;
            ack_src  <= '0;
        end else begin
            state    <= state_n;
            req_q    <= req;
            istb_q   <= istb;
            srv_mask <= srv_mask_n;
            irq      <= irq_n;
            iack     <= iack_n;
            ivec     <= ivec_n;
            ack_src  <= ack_src_n;
        end
    end

endmodule
